hive_vector_resp: RTL

// - Thread-side end of the vector protocol: consumes per-thread clear (clt) / interrupt (irq) issued into the

---
 rtl/hive_vector_resp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hive_vector_resp.sv
// Thread-side vector responder: services clear/interrupt/ISR-return per barrel thread at stage 7.
// Optional HIVE_VECT_SPLIT_EN gives each thread its own vector slot (base + id<<VECT_SHL).
module hive_vector_resp #(
  parameter int unsigned THREADS  = 8,
  parameter int unsigned PC_W     = 16,
  parameter logic [PC_W-1:0] CLT_BASE = 'h0000,
  parameter logic [PC_W-1:0] IRQ_BASE = 'h0020,
  parameter int unsigned VECT_SHL = 2,
  localparam int unsigned ID_W    = $clog2(THREADS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ID_W-1:0]     id_i,
  input  logic                clt_i,
  input  logic                irq_i,
  input  logic                op_irt_i,
  input  logic [PC_W-1:0]     pc_i,
  input  logic [PC_W-1:0]     pc_nxt_i,
  output logic [ID_W-1:0]     id_o,
  output logic [PC_W-1:0]     pc_o,
  output logic                clt_o,
  output logic                irt_o,
  output logic                vec_o,
  output logic                irq_er_o,
  output logic                irt_er_o,
  output logic [THREADS-1:0]  insvc_o
);

`ifdef HIVE_VECT_SPLIT_EN
  localparam logic SPLIT = 1'b1;
`else
  localparam logic SPLIT = 1'b0;
`endif

  typedef enum logic {RUN = 1'b0, ISR = 1'b1} state_t;

  state_t          st_q     [THREADS];
  logic [PC_W-1:0] ret_pc_q [THREADS];

  state_t          cur_st, nxt_st;
  logic            ret_we;
  logic [PC_W-1:0] ret_d;
  logic [PC_W-1:0] pc_d;
  logic            clt_d, irt_d, vec_d, irq_er_d, irt_er_d;
  logic [PC_W-1:0] vec_off, clt_vec, irq_vec;

  // Shared vectors when not split: the offset collapses to zero.
  always_comb begin
    vec_off = SPLIT ? (PC_W'(id_i) << VECT_SHL) : '0;
    clt_vec = CLT_BASE + vec_off;
    irq_vec = IRQ_BASE + vec_off;
  end

  always_comb begin
    cur_st   = st_q[id_i];
    nxt_st   = cur_st;
    ret_we   = 1'b0;
    ret_d    = ret_pc_q[id_i];
    pc_d     = pc_nxt_i;
    clt_d    = 1'b0;
    irt_d    = 1'b0;
    vec_d    = 1'b0;
    irq_er_d = 1'b0;
    irt_er_d = 1'b0;
    if (clt_i) begin
      pc_d   = clt_vec;
      vec_d  = 1'b1;
      clt_d  = 1'b1;
      nxt_st = RUN;
      ret_we = 1'b1;
      ret_d  = '0;
    end else if (irq_i && cur_st == RUN) begin
      // Accepted irq owns the cycle; a same-cycle irt is moot since the thread was not in ISR.
      ret_we = 1'b1;
      ret_d  = pc_i;
      pc_d   = irq_vec;
      vec_d  = 1'b1;
      nxt_st = ISR;
    end else begin
      irq_er_d = irq_i;
      if (op_irt_i) begin
        if (cur_st == ISR) begin
          pc_d   = ret_pc_q[id_i];
          irt_d  = 1'b1;
          vec_d  = 1'b1;
          nxt_st = RUN;
        end else begin
          irt_er_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned t = 0; t < THREADS; t++) begin
        st_q[t]     <= RUN;
        ret_pc_q[t] <= '0;
      end
      id_o     <= '0;
      pc_o     <= CLT_BASE;
      clt_o    <= 1'b0;
      irt_o    <= 1'b0;
      vec_o    <= 1'b0;
      irq_er_o <= 1'b0;
      irt_er_o <= 1'b0;
    end else begin
      st_q[id_i] <= nxt_st;
      if (ret_we) ret_pc_q[id_i] <= ret_d;
      id_o     <= id_i;
      pc_o     <= pc_d;
      clt_o    <= clt_d;
      irt_o    <= irt_d;
      vec_o    <= vec_d;
      irq_er_o <= irq_er_d;
      irt_er_o <= irt_er_d;
    end
  end

  always_comb begin
    for (int unsigned t = 0; t < THREADS; t++) insvc_o[t] = (st_q[t] == ISR);
  end

endmodule
